if_fetch: RTL
=============

# if_fetch

Instruction fetch stage directly upstream of the main control decoder. Holds the program counter and issues one-outstanding requests to instruction memory. Registers each returned instruction into a single output slot with a valid/ready handshake toward decode, and splits out `opcode`/`func3` for the control unit. Branch redirects from execute (taken beq/bge) reload the PC, flush the slot and discard any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-high reset; asserted = 1 despite the suffix.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals `pc`, bits [1:0] always 0.
- `imem_gnt`  in  1  request accepted this cycle when `imem_req && imem_gnt`.
- `imem_rvalid`  in  1  response valid, at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word, qualified by `imem_rvalid`.
- `redirect_valid`  in  1  one-cycle pulse: a branch was taken.
- `redirect_pc`  in  32  branch target; bits [1:0] ignored and forced to 0.
- `if_valid`  out  1  output slot holds a valid instruction.
- `id_ready`  in  1  decode accepts the slot when `if_valid && id_ready`.
- `if_pc`  out  32  PC of the slot instruction.
- `if_instr`  out  32  slot instruction.
- `opcode`  out  7  `if_instr[6:0]`, to main control.
- `func3`  out  3  `if_instr[14:12]`, to main control.
- `fetch_cnt`  out  32  instructions delivered to decode, wraps at 2^32.

## Operation
- State register with three states:
  - FETCH: issue a request.
  - WAIT: a granted request is outstanding.
  - DROP: an outstanding response must be discarded.
- `imem_req = (state==FETCH) && (!if_valid || id_ready) && !redirect_valid && !rst_n`.
- FETCH:
  - On `imem_req && imem_gnt`: `req_pc <= pc`, `pc <= pc + 4` (wraps modulo 2^32), go to WAIT.
  - `imem_rvalid` arriving while in FETCH is ignored.
- WAIT:
  - On `imem_rvalid`: `if_instr <= imem_rdata`, `if_pc <= req_pc`, `if_valid <= 1`, go to FETCH.
  - The slot is guaranteed free at this point, because only one request is ever outstanding and a request is only issued while the slot is empty or being consumed.
- DROP:
  - On `imem_rvalid`: discard the data, `if_valid` is unchanged, go to FETCH.
- Slot consume: on `if_valid && id_ready` with no fill in the same cycle, `if_valid <= 0` and `fetch_cnt` increments.
- Redirect has priority over every other update. In the pulse cycle:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - `if_valid <= 0`; `fetch_cnt` is not incremented even if `id_ready` is high.
  - FETCH stays in FETCH; no request is issued that cycle.
  - WAIT with no `imem_rvalid` goes to DROP.
  - WAIT with `imem_rvalid` in the same cycle discards the data and goes to FETCH.
  - DROP stays in DROP.
- Reset values:
  - state FETCH, `pc = RESET_PC`, `req_pc = RESET_PC`.
  - `if_valid = 0`, `if_instr = 32'h0000_0013` (nop), `if_pc = RESET_PC`.
  - `fetch_cnt = 0`, `imem_req = 0`.
  - Reset mid-operation abandons any outstanding request without entering DROP; instruction memory is reset in the same domain.

## Timing
- Fetch latency: grant in cycle N, response in cycle N+k (k≥1), `if_valid` high in cycle N+k+1.
- Back-to-back: with `imem_gnt` = 1 and k = 1, one instruction every 2 cycles; no prefetch.
- Stall: while `if_valid && !id_ready`, `if_pc`/`if_instr` hold stable and `imem_req` = 0.
- `opcode` and `func3` are purely combinational slices of the slot register.
- Redirect to `if_valid` of the target instruction takes at least 3 cycles (request, response, register).
  - If the redirect hits in WAIT, an extra k cycles are spent in DROP.
- First request: `imem_req` high in the first cycle with `rst_n` = 0.

## Test plan
- Reset release, `imem_gnt` = 1, response one cycle after grant with data 0x00208463:
  - Slot shows `if_pc` = 0x0, `opcode` = 7'b1100011, `func3` = 3'b000.
  - Next `imem_addr` = 0x4.
- Decode stall: hold `id_ready` = 0 for 5 cycles with `if_valid` = 1:
  - `imem_req` stays 0 and the slot stays stable.
  - `fetch_cnt` increments exactly once after `id_ready` rises.
- Redirect in WAIT: grant at PC 0x8, `redirect_pc` = 0x103 pulsed before the response:
  - The response is dropped and no `if_valid` is produced for PC 0x8.
  - Next request address is 0x100.
- Redirect coincident with `imem_rvalid` while the slot holds PC 0x4:
  - Both the slot and the response are discarded, with no `fetch_cnt` increment.
  - Next request address equals the redirect target.
- Reset asserted in WAIT with `if_valid` = 1:
  - Next cycle `if_valid` = 0, `pc` = `RESET_PC`, `fetch_cnt` = 0.
  - A stale `imem_rvalid` arriving afterward is ignored.
- PC wrap: redirect to 0xFFFF_FFFC:
  - Fetch issues 0xFFFF_FFFC, then 0x0000_0000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: program counter, one-outstanding imem requests and a
// single registered output slot toward decode, with branch redirect / flush.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,          // active-high synchronous reset
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        fill;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    fill        = 1'b0;

    imem_req = (state_q == S_FETCH) && (!if_valid_q || id_ready) &&
               !redirect_valid && !rst_n;

    if (redirect_valid) begin
      // Redirect flushes the slot and any in-flight response, overriding all else.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      if_valid_d = 1'b0;
      if (state_q == S_WAIT) state_d = imem_rvalid ? S_FETCH : S_DROP;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_req && imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            fill    = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase

      if (fill) begin
        if_instr_d = imem_rdata;
        if_pc_d    = req_pc_q;
        if_valid_d = 1'b1;
      end else if (if_valid_q && id_ready) begin
        if_valid_d  = 1'b0;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= 32'h0000_0013;
      if_pc_q     <= RESET_PC;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign opcode    = if_instr_q[6:0];
  assign func3     = if_instr_q[14:12];
  assign fetch_cnt = fetch_cnt_q;

endmodule
